psum_accumulator: RTL and testbench

- Consumer at the output end of the adder-tree chain.
- Accepts reduced partial sums (LANES signed lanes of IN_W bits) with a valid/ready handshake and accumulates a programmable number of passes per lane into ACC_W-bit saturating accumulators.
- Presents the finished per-lane results downstream with valid/ready back-pressure.
- Lets a long dot product be computed as several tree passes.

---
 rtl/psum_accumulator_pkg.sv | 14 +
 rtl/psum_accumulator_sat_add.sv | 30 +++
 rtl/psum_accumulator.sv | 120 ++++++++++++
 tb/tb_psum_accumulator.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared types and default widths for the partial-sum accumulator slice.
package psum_accumulator_pkg;

   localparam int INT16  = 16;
   localparam int ACC32  = 32;
   localparam int PASS_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/psum_accumulator_sat_add.sv
// Single-lane signed saturating adder: ACC_W accumulator plus sign-extended IN_W addend.
module psum_sat_add
   import psum_accumulator_pkg::*;
#(
   parameter int IN_W  = INT16,
   parameter int ACC_W = ACC32
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [IN_W-1:0]  add_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             clamp_o
);

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] wide_sum;

   // One guard bit: the top two bits disagree exactly when the true sum left the ACC_W range.
   always_comb begin
      wide_sum = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-IN_W){add_i[IN_W-1]}}, add_i};
      clamp_o  = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
      if (clamp_o) begin
         sum_o = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_o = wide_sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a programmable number of adder-tree passes per lane and hands the
// saturated per-lane results downstream with valid/ready.
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int IN_W   = INT16,
   parameter int ACC_W  = ACC32,
   parameter int PASS_W = PASS_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PASS_W-1:0]       cfg_passes,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*IN_W-1:0]   in_sums,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*ACC_W-1:0]  out_acc,
   output logic [LANES-1:0]        out_sat
);

   state_e                   state_q, state_d;
   logic [PASS_W-1:0]        count_q, count_d;
   logic [PASS_W-1:0]        npass_q, npass_d;
   logic [LANES*ACC_W-1:0]   acc_q, acc_d;
   logic [LANES-1:0]         sat_q, sat_d;

   logic [LANES*ACC_W-1:0]   sum_w;
   logic [LANES*ACC_W-1:0]   sext_w;
   logic [LANES-1:0]         clamp_w;
   logic                     in_fire;
   logic                     out_fire;
   logic                     start_grp;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      psum_sat_add #(
         .IN_W  (IN_W),
         .ACC_W (ACC_W)
      ) u_sat_add (
         .acc_i   (acc_q[l*ACC_W +: ACC_W]),
         .add_i   (in_sums[l*IN_W +: IN_W]),
         .sum_o   (sum_w[l*ACC_W +: ACC_W]),
         .clamp_o (clamp_w[l])
      );

      assign sext_w[l*ACC_W +: ACC_W] =
         {{(ACC_W-IN_W){in_sums[l*IN_W+IN_W-1]}}, in_sums[l*IN_W +: IN_W]};
   end

   assign out_valid = (state_q == ST_DONE);
   assign in_ready  = (state_q != ST_DONE) | out_ready;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_acc   = acc_q;
   assign out_sat   = sat_q;

   // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      npass_d   = npass_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      start_grp = 1'b0;

      case (state_q)
         ST_IDLE: begin
            start_grp = in_fire;
         end
         ST_ACCUM: begin
            if (in_fire) begin
               acc_d   = sum_w;
               sat_d   = sat_q | clamp_w;
               count_d = count_q + PASS_W'(1);
               if (count_d == npass_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (in_fire) begin
               start_grp = 1'b1;
            end else if (out_fire) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A group can open while the previous result drains in the same cycle.
      if (start_grp) begin
         npass_d = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
         acc_d   = sext_w;
         sat_d   = '0;
         count_d = PASS_W'(1);
         state_d = (npass_d == PASS_W'(1)) ? ST_DONE : ST_ACCUM;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over all traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         npass_q <= '0;
         acc_q   <= '0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         npass_q <= npass_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
      end
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Random and directed stimulus against a group-level reference model of the accumulator.
module tb_psum_accumulator;

   localparam int LANES  = 2;
   localparam int IN_W   = 16;
   localparam int ACC_W  = 20;
   localparam int PASS_W = 8;

   localparam longint ACC_HI = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint ACC_LO = -(longint'(1) <<< (ACC_W-1));

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [PASS_W-1:0]       cfg_passes = '0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [LANES*IN_W-1:0]   in_sums = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [LANES*ACC_W-1:0]  out_acc;
   logic [LANES-1:0]        out_sat;

   int n_checks = 0;
   int n_fail   = 0;

   psum_accumulator #(
      .LANES  (LANES),
      .IN_W   (IN_W),
      .ACC_W  (ACC_W),
      .PASS_W (PASS_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_passes (cfg_passes),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sums    (in_sums),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_acc    (out_acc),
      .out_sat    (out_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint lane_acc(input int l);
      logic signed [ACC_W-1:0] v;
      v = out_acc[l*ACC_W +: ACC_W];
      return longint'(v);
   endfunction

   function automatic longint lane_in(input int l);
      logic signed [IN_W-1:0] v;
      v = in_sums[l*IN_W +: IN_W];
      return longint'(v);
   endfunction

   task automatic set_sums(input longint a, input longint b);
      in_sums = {IN_W'(b), IN_W'(a)};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a group is a list of accepted beats summed with clamping;
   // a completed group becomes the presented result until the consumer takes it.
   bit     m_init  = 1'b0;
   bit     m_valid = 1'b0;
   bit     m_busy  = 1'b0;
   int     m_n, m_cnt;
   longint m_acc [LANES];
   bit     m_sat [LANES];
   longint r_acc [LANES];
   bit     r_sat [LANES];

   always @(posedge clk) begin
      bit fi, fo;
      longint s;
      if (reset) begin
         m_init  = 1'b1;
         m_valid = 1'b0;
         m_busy  = 1'b0;
         for (int l = 0; l < LANES; l++) begin
            r_acc[l] = 0;
            r_sat[l] = 1'b0;
         end
      end else if (m_init) begin
         fi = in_valid && (!m_valid || out_ready);
         fo = m_valid && out_ready;
         if (fo) m_valid = 1'b0;
         if (fi) begin
            if (!m_busy) begin
               m_n    = (cfg_passes == 0) ? 1 : int'(cfg_passes);
               m_cnt  = 0;
               m_busy = 1'b1;
               for (int l = 0; l < LANES; l++) begin
                  m_acc[l] = 0;
                  m_sat[l] = 1'b0;
               end
            end
            for (int l = 0; l < LANES; l++) begin
               s = m_acc[l] + lane_in(l);
               if (s > ACC_HI) begin
                  s = ACC_HI;
                  m_sat[l] = 1'b1;
               end else if (s < ACC_LO) begin
                  s = ACC_LO;
                  m_sat[l] = 1'b1;
               end
               m_acc[l] = s;
            end
            m_cnt++;
            if (m_cnt == m_n) begin
               m_busy  = 1'b0;
               m_valid = 1'b1;
               for (int l = 0; l < LANES; l++) begin
                  r_acc[l] = m_acc[l];
                  r_sat[l] = m_sat[l];
               end
            end
         end
      end
   end

   // Result outputs are only defined while a result is presented or the block is idle.
   always @(negedge clk) begin
      if (m_init) begin
         check("in_ready", longint'(in_ready), longint'(!m_valid || out_ready));
         check("out_valid", longint'(out_valid), longint'(m_valid));
         if (m_valid || !m_busy) begin
            for (int l = 0; l < LANES; l++) begin
               check($sformatf("out_acc[%0d]", l), lane_acc(l), r_acc[l]);
               check($sformatf("out_sat[%0d]", l), longint'(out_sat[l]), longint'(r_sat[l]));
            end
         end
      end
   end

   initial begin
      // Reset state
      reset = 1'b1;
      step();
      step();
      @(negedge clk);
      check("rst in_ready", longint'(in_ready), 1);
      check("rst out_valid", longint'(out_valid), 0);
      check("rst out_acc", longint'(out_acc), 0);
      check("rst out_sat", longint'(out_sat), 0);
      step();
      reset = 1'b0;

      // Four back-to-back beats, N=4
      cfg_passes = 8'd4;
      set_sums(1, -2);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("n4 early valid", longint'(out_valid), 0);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("n4 valid", longint'(out_valid), 1);
      check("n4 lane0", lane_acc(0), 4);
      check("n4 lane1", lane_acc(1), -8);
      check("n4 sat", longint'(out_sat), 0);
      step();
      @(negedge clk);
      check("n4 drained", longint'(out_valid), 0);

      // cfg_passes=0 acts as a single-beat group
      step();
      cfg_passes = 8'd0;
      set_sums(32767, -32768);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("n0 valid", longint'(out_valid), 1);
      check("n0 lane0", lane_acc(0), 32767);
      check("n0 lane1", lane_acc(1), -32768);

      // N=255 with lane 0 driven into positive saturation
      step();
      cfg_passes = 8'd255;
      set_sums(32767, 1);
      in_valid = 1'b1;
      for (int i = 0; i < 255; i++) step();
      in_valid = 1'b0;
      @(negedge clk);
      check("n255 valid", longint'(out_valid), 1);
      check("n255 lane0", lane_acc(0), 524287);
      check("n255 lane1", lane_acc(1), 255);
      check("n255 sat", longint'(out_sat), 1);
      step();

      // Back-pressure then drain-and-restart in the same cycle
      out_ready  = 1'b0;
      cfg_passes = 8'd2;
      in_valid   = 1'b1;
      set_sums(10, 20);
      step();
      set_sums(30, 40);
      step();
      set_sums(5, 6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp in_ready", longint'(in_ready), 0);
         check("bp valid", longint'(out_valid), 1);
         check("bp lane0", lane_acc(0), 40);
         check("bp lane1", lane_acc(1), 60);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release in_ready", longint'(in_ready), 1);
      step();
      set_sums(7, 8);
      @(negedge clk);
      check("restart mid valid", longint'(out_valid), 0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("restart valid", longint'(out_valid), 1);
      check("restart lane0", lane_acc(0), 12);
      check("restart lane1", lane_acc(1), 14);
      step();

      // Bubbles and a mid-group cfg change
      cfg_passes = 8'd3;
      set_sums(100, -1);
      in_valid = 1'b1;
      step();
      in_valid   = 1'b0;
      cfg_passes = 8'd5;
      step();
      set_sums(200, -2);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      set_sums(300, -3);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("bubble valid", longint'(out_valid), 1);
      check("bubble lane0", lane_acc(0), 600);
      check("bubble lane1", lane_acc(1), -6);
      step();

      // Reset in the middle of a group
      cfg_passes = 8'd4;
      set_sums(9, 9);
      in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("midrst valid", longint'(out_valid), 0);
      check("midrst acc", longint'(out_acc), 0);
      check("midrst in_ready", longint'(in_ready), 1);
      step();
      cfg_passes = 8'd1;
      set_sums(3, 4);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("post rst valid", longint'(out_valid), 1);
      check("post rst lane0", lane_acc(0), 3);
      check("post rst lane1", lane_acc(1), 4);
      step();

      // Randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_sums   = LANES*IN_W'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            cfg_passes = ($urandom_range(0, 9) == 0) ? PASS_W'($urandom_range(20, 60))
                                                     : PASS_W'($urandom_range(0, 6));
         end
         step();
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
